// File: rtl/bus_fabric.sv
// rtl/bus_fabric.sv - single-master bus fabric with windowed decode, ready handshake and timeout
module bus_fabric #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int N_SLAVES   = 4,
  parameter int SLOT_SHIFT = 13,
  parameter int SLOT_W     = 3,
  parameter int TIMEOUT    = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cpu_req,
  input  logic                         cpu_we,
  input  logic [ADDR_W-1:0]            cpu_addr,
  input  logic [DATA_W-1:0]            cpu_wdata,
  input  logic [DATA_W/8-1:0]          cpu_wstrb,
  output logic [DATA_W-1:0]            cpu_rdata,
  output logic                         cpu_ready,
  output logic                         cpu_err,
  output logic [N_SLAVES-1:0]          s_sel,
  output logic                         s_we,
  output logic [ADDR_W-1:0]            s_addr,
  output logic [DATA_W-1:0]            s_wdata,
  output logic [DATA_W/8-1:0]          s_wstrb,
  input  logic [N_SLAVES*DATA_W-1:0]   s_rdata,
  input  logic [N_SLAVES-1:0]          s_ready
);

  localparam int STRB_W = DATA_W / 8;
  localparam int HI_LSB = SLOT_SHIFT + SLOT_W;
  // A zero TIMEOUT still needs a one-bit counter so the flop is legal; it never moves.
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << SLOT_SHIFT) - 64'd1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e              state_q, state_d;
  logic [N_SLAVES-1:0] sel_q, sel_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                ready_q, ready_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [31:0]         slot32;
  logic                dec_err;
  logic [N_SLAVES-1:0] dec_sel;
  logic [DATA_W-1:0]   sel_rdata;
  logic                sel_ready;
  logic                timeout_hit;

  // Address decode of the incoming request: slot index, window range and word alignment.
  always_comb begin
    slot32  = 32'(cpu_addr[SLOT_SHIFT +: SLOT_W]);
    dec_err = (|(cpu_addr >> HI_LSB)) || (slot32 >= 32'(N_SLAVES)) || (cpu_addr[1:0] != 2'b00);
    dec_sel = '0;
    for (int k = 0; k < N_SLAVES; k++) dec_sel[k] = (slot32 == 32'(k));
  end

  // Only the selected slave's ready and read data are visible; stray readies are masked off.
  always_comb begin
    sel_rdata = '0;
    for (int k = 0; k < N_SLAVES; k++) begin
      if (sel_q[k]) sel_rdata = sel_rdata | s_rdata[k*DATA_W +: DATA_W];
    end
    sel_ready   = |(s_ready & sel_q);
    timeout_hit = (TIMEOUT != 0) && ((32'(cnt_q) + 32'd1) >= 32'(TIMEOUT));
  end

  // Next-state and registered outputs of the IDLE/ACCESS/RESP transaction FSM.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          if (dec_err) begin
            state_d = RESP;
            ready_d = 1'b1;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = ACCESS;
            sel_d   = dec_sel;
            we_d    = cpu_we;
            addr_d  = cpu_addr & OFF_MASK;
            wdata_d = cpu_wdata;
            wstrb_d = cpu_wstrb;
            cnt_d   = '0;
          end
        end
      end
      ACCESS: begin
        if (sel_ready) begin
          state_d = RESP;
          sel_d   = '0;
          ready_d = 1'b1;
          rdata_d = we_q ? '0 : sel_rdata;
        end else if (timeout_hit) begin
          state_d = RESP;
          sel_d   = '0;
          ready_d = 1'b1;
          err_d   = 1'b1;
          rdata_d = '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        // Response lasts one cycle; the read data is cleared so it cannot be mistaken later.
        state_d = IDLE;
        rdata_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any transaction without a response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cpu_rdata = rdata_q;
  assign cpu_ready = ready_q;
  assign cpu_err   = err_q;
  assign s_sel     = sel_q;
  assign s_we      = we_q;
  assign s_addr    = addr_q;
  assign s_wdata   = wdata_q;
  assign s_wstrb   = wstrb_q;

endmodule

// File: tb/tb_bus_fabric.sv
// tb/tb_bus_fabric.sv - directed self-checking bench for bus_fabric
module tb_bus_fabric;

  logic         clk;
  logic         rst;
  logic         cpu_req, cpu_req_b;
  logic         cpu_we;
  logic [31:0]  cpu_addr;
  logic [31:0]  cpu_wdata;
  logic [3:0]   cpu_wstrb;
  logic [127:0] s_rdata;
  logic [3:0]   s_ready;

  logic [31:0]  cpu_rdata, b_rdata;
  logic         cpu_ready, b_ready;
  logic         cpu_err, b_err;
  logic [3:0]   s_sel, b_sel;
  logic         s_we, b_we;
  logic [31:0]  s_addr, b_addr;
  logic [31:0]  s_wdata, b_wdata;
  logic [3:0]   s_wstrb, b_wstrb;

  int n_total = 0;
  int n_bad   = 0;

  bus_fabric dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb), .cpu_rdata(cpu_rdata),
    .cpu_ready(cpu_ready), .cpu_err(cpu_err), .s_sel(s_sel), .s_we(s_we),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_rdata(s_rdata),
    .s_ready(s_ready)
  );

  bus_fabric #(.TIMEOUT(8)) dut_to (
    .clk(clk), .rst(rst), .cpu_req(cpu_req_b), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb), .cpu_rdata(b_rdata),
    .cpu_ready(b_ready), .cpu_err(b_err), .s_sel(b_sel), .s_we(b_we),
    .s_addr(b_addr), .s_wdata(b_wdata), .s_wstrb(b_wstrb), .s_rdata(s_rdata),
    .s_ready(s_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic err_case(input string tag, input logic [31:0] addr);
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = addr;
    tick();
    check({tag, "_ready"}, cpu_ready, 1);
    check({tag, "_err"}, cpu_err, 1);
    check({tag, "_rdata"}, cpu_rdata, 0);
    check({tag, "_sel_resp"}, s_sel, 0);
    cpu_req = 1'b0;
    tick();
    check({tag, "_ready_drop"}, cpu_ready, 0);
    check({tag, "_sel_after"}, s_sel, 0);
  endtask

  initial begin
    int unstable, acc, hit, pulses, p1, p2, stray;
    rst = 1'b0; cpu_req = 1'b0; cpu_req_b = 1'b0; cpu_we = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0; s_ready = '0;
    s_rdata = {32'h3333_3333, 32'h2222_2222, 32'hCAFE_BABE, 32'h1111_0000};

    // Reset values
    repeat (2) tick();
    check("rst_ready", cpu_ready, 0);
    check("rst_err", cpu_err, 0);
    check("rst_rdata", cpu_rdata, 0);
    check("rst_sel", s_sel, 0);
    check("rst_we", s_we, 0);
    check("rst_addr", s_addr, 0);
    check("rst_wdata", s_wdata, 0);
    check("rst_wstrb", s_wstrb, 0);
    rst = 1'b1;

    // RAM read with ready in the first ACCESS cycle: cpu_ready lands in the third cycle of the request
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h2010;
    tick();
    check("ram_sel", s_sel, 4'b0010);
    check("ram_addr", s_addr, 32'h10);
    check("ram_we", s_we, 0);
    check("ram_early_ready", cpu_ready, 0);
    s_ready = 4'b0010;
    tick();
    check("ram_ready", cpu_ready, 1);
    check("ram_rdata", cpu_rdata, 32'hCAFE_BABE);
    check("ram_err", cpu_err, 0);
    check("ram_sel_resp", s_sel, 0);
    cpu_req = 1'b0; s_ready = 4'b0000;
    tick();
    check("ram_one_pulse", cpu_ready, 0);

    // UART write stalled for 20 cycles
    tick();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h4000; cpu_wdata = 32'h41; cpu_wstrb = 4'b0001;
    unstable = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (s_sel !== 4'b0100 || s_wdata !== 32'h41 || s_we !== 1'b1 || s_addr !== 32'h0 ||
          s_wstrb !== 4'b0001 || cpu_ready !== 1'b0) unstable++;
    end
    check("uart_stable", unstable, 0);
    tick();
    s_ready = 4'b0100;
    tick();
    check("uart_ready", cpu_ready, 1);
    check("uart_err", cpu_err, 0);
    check("uart_rdata_wr", cpu_rdata, 0);
    cpu_req = 1'b0; s_ready = 4'b0000;
    tick();
    check("uart_one_pulse", cpu_ready, 0);

    // Decode errors: unmapped slot, misaligned, out-of-window high bits
    err_case("unmapped", 32'h8000);
    err_case("misalign", 32'h2002);
    err_case("hibits", 32'h0001_0000);

    // Timeout on the TIMEOUT=8 instance: ROM never answers
    tick();
    cpu_req_b = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0;
    acc = 0; hit = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (b_ready) begin
        hit = i;
        check("to_err", b_err, 1);
        check("to_rdata", b_rdata, 0);
        check("to_sel_resp", b_sel, 0);
        break;
      end
      if (b_sel == 4'b0001) acc++;
    end
    check("to_access_cycles", acc, 8);
    check("to_resp_cycle", hit, 9);
    cpu_req_b = 1'b0;
    tick();
    check("to_one_pulse", b_ready, 0);

    // Back-to-back write RAM then read ROM with cpu_req held; s_ready[3] toggles throughout
    tick();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h2004; cpu_wdata = 32'hDEAD_BEEF; cpu_wstrb = 4'hF;
    pulses = 0; p1 = 0; p2 = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 1) begin
        check("b2b_wr_sel", s_sel, 4'b0010);
        check("b2b_wr_data", s_wdata, 32'hDEAD_BEEF);
      end
      if (c == 3) check("b2b_gap_sel", s_sel, 0);
      if (c == 4) begin
        check("b2b_rd_sel", s_sel, 4'b0001);
        check("b2b_rd_addr", s_addr, 32'h8);
      end
      if (cpu_ready) begin
        pulses++;
        if (pulses == 1) begin
          p1 = c;
          check("b2b_wr_err", cpu_err, 0);
          cpu_we = 1'b0; cpu_addr = 32'h0008;
        end else if (pulses == 2) begin
          p2 = c;
          check("b2b_rd_rdata", cpu_rdata, 32'h1111_0000);
          check("b2b_rd_err", cpu_err, 0);
          cpu_req = 1'b0;
        end
      end
      s_ready = {c[0], 1'b0, (c == 1), (c == 6)};
    end
    s_ready = 4'b0000;
    check("b2b_pulses", pulses, 2);
    check("b2b_first", p1, 2);
    check("b2b_second", p2, 7);

    // Asynchronous reset in the middle of a RAM access
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h2010;
    tick();
    check("rmid_sel_before", s_sel, 4'b0010);
    #2 rst = 1'b0;
    #1;
    check("rmid_sel", s_sel, 0);
    check("rmid_ready", cpu_ready, 0);
    check("rmid_err", cpu_err, 0);
    tick();
    cpu_req = 1'b0; rst = 1'b1;
    stray = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (cpu_ready !== 1'b0 || s_sel !== 4'b0000) stray++;
    end
    check("rmid_no_stray", stray, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/bus_fabric.md
Name: bus_fabric

Overview:
- Parametrised single-master system bus fabric; next generation of the fixed combinational ROM/RAM/UART address decoder.
- Sits between the core's data port and N memory-mapped slaves (ROM, RAM, UART, VRAM, timers, ...).
- Decodes fixed-size address windows and registers each transaction.
- Runs a request/ready handshake so slow or busy slaves stall the core instead of losing data.
- Returns an error response for unmapped, misaligned or timed-out accesses.

Parameters:
- ADDR_W, 32, bus address width
- DATA_W, 32, bus data width; must be a multiple of 8
- N_SLAVES, 4, number of slave windows (slot 0 = ROM, 1 = RAM, 2 = UART, 3 = VRAM)
- SLOT_SHIFT, 13, log2 of window size (8 KiB); slot index = addr[SLOT_SHIFT+SLOT_W-1:SLOT_SHIFT]
- SLOT_W, 3, width of the slot index field; N_SLAVES <= 2**SLOT_W
- TIMEOUT, 255, cycles to wait for s_ready before an error response; 0 disables the timeout

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- cpu_req  in  1  transaction request; held until cpu_ready
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  byte address
- cpu_wdata  in  DATA_W  write data
- cpu_wstrb  in  DATA_W/8  byte enables for writes
- cpu_rdata  out  DATA_W  read data; valid only while cpu_ready=1
- cpu_ready  out  1  one-cycle completion pulse
- cpu_err  out  1  qualifies cpu_ready; 1 = error response
- s_sel  out  N_SLAVES  one-hot slave select; held for the whole access
- s_we  out  1  registered write flag
- s_addr  out  ADDR_W  registered address, offset within window (upper bits zeroed)
- s_wdata  out  DATA_W  registered write data
- s_wstrb  out  DATA_W/8  registered byte enables
- s_rdata  in  N_SLAVES*DATA_W  packed slave read data; slot k at [k*DATA_W +: DATA_W]
- s_ready  in  N_SLAVES  per-slave completion; only the selected bit is honoured

Behaviour:
- Reset (rst=0, async): state=IDLE.
  - cpu_ready=0, cpu_err=0, cpu_rdata=0.
  - s_sel=0, s_we=0, s_addr=0, s_wdata=0, s_wstrb=0.
  - Timeout counter=0.
  - Reset mid-transaction abandons the transaction silently; no response is issued.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, cpu_req=1, transaction sampled and registered:
  - Slot >= N_SLAVES, address bits above the slot field nonzero, or addr[1:0]!=0 -> go to RESP with err=1 and rdata=0.
  - Otherwise -> ACCESS; s_sel asserted one cycle after the request is sampled.
- ACCESS:
  - s_sel and all s_* outputs are held stable.
  - s_ready[slot]=1 -> latch the slot's s_rdata (forced to 0 on writes), err=0, go to RESP.
  - If the timeout is enabled and the counter reaches TIMEOUT before s_ready -> err=1, rdata=0, go to RESP.
  - s_ready bits of unselected slaves are ignored.
- RESP:
  - cpu_ready=1 for exactly one cycle; cpu_err and cpu_rdata are valid in that cycle.
  - s_sel=0 in this cycle.
  - Next state is always IDLE; a new request is not sampled in RESP.
- Latency:
  - Minimum access is 3 cycles from request sample to cpu_ready (slave ready in the first ACCESS cycle).
  - Error-decode path is 2 cycles.
- Throughput: one transaction in flight; a back-to-back request is sampled in the IDLE cycle after RESP.
- Timeout counter:
  - Width is ceil(log2(TIMEOUT+1)); it saturates and never wraps.
  - Cleared on entry to ACCESS.
- Core protocol: cpu_addr, cpu_we, cpu_wdata and cpu_wstrb must not change while cpu_req=1 and cpu_ready=0. The fabric samples them only in IDLE.
- Write with cpu_wstrb=0 is forwarded normally; the slave decides what to do with it.
- UART busy is expressed by the UART slave holding s_ready low. No status polling is needed for correctness.

Test Plan:
- Reset mid-ACCESS: RAM read in flight, rst pulsed low asynchronously -> s_sel, cpu_ready and cpu_err drop to 0 immediately; after release, state is IDLE and no stray cpu_ready appears.
- RAM read: cpu_addr=0x2010, s_ready[1] returned one cycle after s_sel=4'b0010, s_rdata slot1=0xCAFEBABE -> s_addr=0x0010; cpu_ready pulses once, 3 cycles after the request, with cpu_rdata=0xCAFEBABE and cpu_err=0.
- UART stall: write 0x41 to 0x4000, s_ready[2] held low for 20 cycles -> s_sel=4'b0100 and s_wdata=0x41 stay stable for all 20 cycles; cpu_ready is asserted one cycle after s_ready, with err=0.
- Unmapped and misaligned:
  - cpu_addr=0x8000 (slot 4) -> cpu_ready with err=1 and rdata=0 two cycles after the request; s_sel never asserts.
  - cpu_addr=0x2002 -> same error response; s_sel never asserts.
- Timeout: TIMEOUT=8, ROM slave never asserts s_ready -> cpu_ready with err=1 after exactly 8 ACCESS cycles; s_sel=0 in the RESP cycle.
- Back-to-back plus ignored ready: write RAM then read ROM with cpu_req held continuously; s_ready[3] toggled throughout -> two distinct cpu_ready pulses separated by one IDLE cycle; the stray s_ready[3] toggles have no effect.
